// File: rtl/sequence_player.sv
// Plays a stored colour sequence on the RGB LED: fetch one code per step from
// a synchronous-read memory, light it for on_len cycles, then go dark for off_len.
module sequence_player #(
  parameter int MAX_LEN   = 32,
  parameter int ADDR_W    = 5,
  parameter int ON_TICKS  = 50000,
  parameter int OFF_TICKS = 25000
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W:0]   length_i,
  input  logic [1:0]        speed_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [1:0]        mem_data_i,
  output logic [2:0]        led_rgb_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int LW   = ADDR_W + 1;
  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ON, OFF, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [TW-1:0]     on_len_q, on_len_d;
  logic [TW-1:0]     off_len_q, off_len_d;
  logic [LW-1:0]     len_q, len_d;
  logic [1:0]        colour_q, colour_d;

  logic [TW-1:0]     on_calc, off_calc;
  logic [LW-1:0]     len_sat;
  logic              last_elem;

  // Level shortens both phases; never let a phase collapse to zero cycles.
  always_comb begin
    on_calc  = TW'(ON_TICKS >> speed_i);
    off_calc = TW'(OFF_TICKS >> speed_i);
    if (on_calc == '0)  on_calc  = TW'(1);
    if (off_calc == '0) off_calc = TW'(1);
  end

  assign len_sat   = (length_i > LW'(MAX_LEN)) ? LW'(MAX_LEN) : length_i;
  assign last_elem = ({1'b0, index_q} == (len_q - LW'(1)));

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    addr_d    = addr_q;
    timer_d   = timer_q;
    on_len_d  = on_len_q;
    off_len_d = off_len_q;
    len_d     = len_q;
    colour_d  = colour_q;
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      index_d = '0;
    end else begin
      case (state_q)
        IDLE: if (start_i && !abort_i) begin
          len_d     = len_sat;
          on_len_d  = on_calc;
          off_len_d = off_calc;
          index_d   = '0;
          if (len_sat == '0) state_d = DONE;
          else begin
            state_d = FETCH;
            addr_d  = '0;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          colour_d = mem_data_i;
          timer_d  = on_len_q - TW'(1);
          state_d  = ON;
        end
        ON: begin
          if (timer_q != '0) timer_d = timer_q - TW'(1);
          else begin
            timer_d = off_len_q - TW'(1);
            state_d = OFF;
          end
        end
        OFF: begin
          if (timer_q != '0) timer_d = timer_q - TW'(1);
          else if (last_elem) state_d = DONE;
          else begin
            // Address is registered on FETCH entry so it holds between reads.
            index_d = index_q + ADDR_W'(1);
            addr_d  = index_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      index_q   <= '0;
      addr_q    <= '0;
      timer_q   <= '0;
      on_len_q  <= '0;
      off_len_q <= '0;
      len_q     <= '0;
      colour_q  <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      addr_q    <= addr_d;
      timer_q   <= timer_d;
      on_len_q  <= on_len_d;
      off_len_q <= off_len_d;
      len_q     <= len_d;
      colour_q  <= colour_d;
    end
  end

  always_comb begin
    led_rgb_o = 3'b000;
    if (state_q == ON) begin
      case (colour_q)
        2'b00:   led_rgb_o = 3'b100;
        2'b01:   led_rgb_o = 3'b001;
        2'b10:   led_rgb_o = 3'b110;
        default: led_rgb_o = 3'b010;
      endcase
    end
  end

  assign mem_rd_o   = (state_q == FETCH);
  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: builds the expected per-cycle output trace of each
// playback from the timing rules and compares it cycle by cycle.
module tb_sequence_player;
  localparam int MAX_LEN = 32;
  localparam int ADDR_W  = 5;
  localparam int ON_T    = 8;
  localparam int OFF_T   = 4;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [5:0] length = '0;
  logic [1:0] speed = '0;
  logic       mem_rd, busy, done;
  logic [4:0] mem_addr;
  logic [1:0] mem_data = '0;
  logic [2:0] led;

  logic [1:0]  mem [MAX_LEN];
  logic [10:0] q[$];
  logic [4:0]  exp_addr = '0;
  int total = 0, passed = 0;

  sequence_player #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T)) dut (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start), .abort_i(abort),
    .length_i(length), .speed_i(speed), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
    .mem_data_i(mem_data), .led_rgb_o(led), .busy_o(busy), .done_o(done));

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  function automatic logic [2:0] col(input logic [1:0] c);
    case (c)
      2'b00:   return 3'b100;
      2'b01:   return 3'b001;
      2'b10:   return 3'b110;
      default: return 3'b010;
    endcase
  endfunction

  // Observed/expected layout: {rd, addr[4:0], led[2:0], busy, done}
  task automatic chk(input string tag, input int cyc, input logic [10:0] exp);
    logic [10:0] obs;
    obs = {mem_rd, mem_addr, led, busy, done};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc %0d got rd/addr/led/busy/done=%b/%0d/%b/%b/%b want %b/%0d/%b/%b/%b",
                tag, cyc, obs[10], obs[9:5], obs[4:2], obs[1], obs[0],
                exp[10], exp[9:5], exp[4:2], exp[1], exp[0]);
  endtask

  task automatic play(input string tag, input int len, input int spd, input int abort_cyc,
                      input int bstart_cyc);
    int n, on, off, ab;
    logic [4:0]  last;
    logic [10:0] e;
    n   = (len > MAX_LEN) ? MAX_LEN : len;
    on  = ON_T >> spd;  if (on < 1)  on = 1;
    off = OFF_T >> spd; if (off < 1) off = 1;
    q.delete();
    for (int k = 0; k < n; k++) begin
      q.push_back({1'b1, 5'(k), 3'b000, 1'b1, 1'b0});
      q.push_back({1'b0, 5'(k), 3'b000, 1'b1, 1'b0});
      for (int i = 0; i < on; i++)  q.push_back({1'b0, 5'(k), col(mem[k]), 1'b1, 1'b0});
      for (int i = 0; i < off; i++) q.push_back({1'b0, 5'(k), 3'b000, 1'b1, 1'b0});
    end
    last = (n > 0) ? 5'(n - 1) : exp_addr;
    q.push_back({1'b0, last, 3'b000, 1'b1, 1'b1});
    ab = (abort_cyc > q.size()) ? 0 : abort_cyc;
    if (ab > 0) while (q.size() > ab) void'(q.pop_back());
    e = q[q.size() - 1];
    q.push_back({1'b0, e[9:5], 3'b000, 1'b0, 1'b0});
    exp_addr = e[9:5];

    @(negedge clk);
    start = 1'b1; length = 6'(len); speed = 2'(spd);
    for (int c = 1; c <= q.size(); c++) begin
      @(negedge clk);
      chk(tag, c, q[c - 1]);
      start = (c == bstart_cyc);
      if (start) begin length = 6'd2; speed = 2'd3; end
      abort = (c == ab);
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MAX_LEN; i++) mem[i] = 2'($urandom);

    // Reset held with start toggling: everything stays low
    length = 6'd3;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("reset", c, 11'b0);
      start = ~start;
    end
    start = 1'b0;
    rst_n = 1'b1;

    mem[0] = 2'b00; mem[1] = 2'b01; mem[2] = 2'b11;
    play("three", 3, 0, 0, 0);
    play("fast", 3, 3, 0, 0);
    play("zero", 0, 0, 0, 0);
    play("abort", 3, 0, 19, 0);
    play("restart", 3, 0, 0, 0);

    // abort and start together in IDLE: abort wins
    @(negedge clk); start = 1'b1; abort = 1'b1; length = 6'd3;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", 1, {1'b0, exp_addr, 3'b000, 1'b0, 1'b0});
    @(negedge clk);
    chk("abort_start_idle", 2, {1'b0, exp_addr, 3'b000, 1'b0, 1'b0});

    for (int i = 0; i < MAX_LEN; i++) mem[i] = 2'($urandom);
    play("saturate", 40, 3, 0, 30);
    play("abort_done", 2, 2, 13, 0);

    for (int t = 0; t < 8; t++) begin
      int l, s, a;
      for (int i = 0; i < MAX_LEN; i++) mem[i] = 2'($urandom);
      l = $urandom_range(0, 40);
      s = $urandom_range(0, 3);
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
      play("random", l, s, a, $urandom_range(2, 20));
    end

    // Asynchronous reset mid-playback
    @(negedge clk); start = 1'b1; length = 6'd5; speed = 2'd0;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_reset", 0, 11'b0);
    @(negedge clk);
    chk("mid_reset", 1, 11'b0);
    rst_n = 1'b1;
    exp_addr = '0;
    play("after_reset", 2, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sequence_player.md
Name: sequence_player

Overview:
- Plays back the stored colour sequence on the RGB LED for the game controller.
- Sits between the main game FSM and the sequence memory. It is started by the game FSM during "Modo Simon" display phases.
- Fetches one colour code per step from a synchronous-read memory and lights the LED for a level-dependent on-time, then holds it dark for an off-time.
- Reports completion with a single-cycle done pulse. It is the sole reader of the sequence memory while busy.

Parameters:
- MAX_LEN, 32, maximum sequence length (entries).
- ADDR_W, 5, memory address width (clog2 of MAX_LEN).
- ON_TICKS, 50000, LED-on duration in clock cycles at level 0.
- OFF_TICKS, 25000, LED-off gap in clock cycles at level 0.

Ports:
- clock, input, 1, system clock; all state on rising edge.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, request playback; sampled only in IDLE.
- abort, input, 1, cancel playback from any state.
- length, input, ADDR_W+1, number of entries to play; sampled with start.
- speed, input, 2, game level; sampled with start.
- mem_rd, output, 1, read strobe to sequence memory.
- mem_addr, output, ADDR_W, read address.
- mem_data, input, 2, colour code; valid the cycle after mem_rd.
- led_rgb, output, 3, LED drive {R,G,B}.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, index=0, timer=0, colour register=0. All outputs are 0: mem_rd, mem_addr, led_rgb, busy, done.
- All outputs are decoded from registered state only; no combinational path from inputs to outputs.
- Colour decode (mem_data to led_rgb):
  - 00 red = 100
  - 01 blue = 001
  - 10 yellow = 110
  - 11 green = 010
- Timing from speed:
  - on_len = max(ON_TICKS >> speed, 1)
  - off_len = max(OFF_TICKS >> speed, 1)
  - Both are latched at start.
- Length handling: length is latched at start and saturated to MAX_LEN if larger.

States:
- IDLE:
  - start=1 and abort=0, latched length=0: go to DONE.
  - start=1 and abort=0, length nonzero: index=0, go to FETCH.
- FETCH (1 cycle): mem_rd=1, mem_addr=index; go to LOAD.
- LOAD (1 cycle): capture mem_data into the colour register, timer=on_len-1; go to ON.
- ON:
  - led_rgb=decoded colour.
  - timer>0: decrement.
  - timer=0: timer=off_len-1, go to OFF.
- OFF:
  - led_rgb=000.
  - timer>0: decrement.
  - timer=0 and index=length-1: go to DONE.
  - timer=0 otherwise: index+1, go to FETCH.
- DONE (1 cycle): done=1; go to IDLE.

Cycle-level rules:
- Each element occupies exactly 2+on_len+off_len cycles.
- With start sampled at edge 0, FETCH for element k begins at cycle 1+k*(2+on_len+off_len).
- done is high in cycle 1+N*(2+on_len+off_len) for N entries.
- led_rgb is nonzero only in ON cycles.
- mem_rd is high only in FETCH; mem_addr holds its last value otherwise.

Boundary conditions:
- start while busy: ignored; no re-latching of length or speed.
- abort=1 in any non-IDLE state: next cycle IDLE, led_rgb=000, busy=0, no done pulse, index=0.
- abort and start in the same IDLE cycle: abort wins; stay in IDLE.
- abort in DONE: the done pulse for that cycle is already asserted and is not suppressed.
- index never exceeds MAX_LEN-1; no wrap-around within a playback.
- Reset asserted mid-operation: immediate return to reset values regardless of state.

Test Plan:
1. Reset:
   - Stimulus: hold reset=0 with start=1 toggling; then release.
   - Response: all outputs 0 throughout; first start after release is accepted.
2. Three-entry playback (ON_TICKS=8, OFF_TICKS=4, speed=0, memory {00,01,11}, length=3):
   - led_rgb: 100 for 8 cycles, 000 for 4, 001 for 8, 000 for 4, 010 for 8, 000 for 4.
   - mem_addr=0,1,2 on the mem_rd cycles.
   - done high in cycle 43 only; busy high in cycles 1–43.
3. Fast level (same setup, speed=3):
   - on_len=1 and off_len=1 (minimum clamp), so each element takes 4 cycles.
   - done in cycle 13.
4. Zero length (length=0):
   - busy=1 and done=1 in cycle 1 only.
   - mem_rd never asserted; led_rgb stays 000.
5. Abort and restart:
   - Stimulus: abort during the 3rd ON cycle of element 1; then start again.
   - Response: led_rgb=000 and busy=0 on the next cycle, no done. The restart plays from mem_addr=0.
6. Saturation and busy start (length=40):
   - Exactly 32 reads occur, addresses 0..31; done follows the 32nd element.
   - A start pulsed mid-playback with length=2 has no effect.
